// File: rtl/memory_access_stage.sv
// memory_access_stage: RISC-V MEM stage with a valid/ready load/store bus, forwarding and MEM/WB register
module memory_access_stage #(
    parameter logic [5:0] NO_REG      = 6'h3F,
    parameter int         BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EXMEM_ready,
    input  logic [63:0] exmm_aluresult,
    input  logic [5:0]  dest_reg,
    input  logic        mem_active,
    input  logic        load,
    input  logic [63:0] store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        mem_stall,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic [63:0] dreq_addr,
    output logic        dreq_write,
    output logic [63:0] dreq_wdata,
    output logic [7:0]  dreq_strb,
    input  logic        dresp_valid,
    input  logic [63:0] dresp_data,
    output logic [5:0]  MEMEX_rd,
    output logic [63:0] MEMEX_rdval,
    output logic        MEMWB_ready,
    output logic [5:0]  memwb_rd,
    output logic [63:0] memwb_rdval,
    output logic        mem_err
);
    localparam int CW = $clog2(BUS_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t        state_q;
    logic [63:0]   addr_q, wdata_q, memwb_rdval_q;
    logic [7:0]    strb_q;
    logic [1:0]    size_q;
    logic [5:0]    rd_q, memwb_rd_q;
    logic [CW-1:0] cnt_q;
    logic          write_q, uns_q, memwb_ready_q, mem_err_q;
    logic [2:0]    off_d, amask_d;
    logic          misaligned_d;
    logic [7:0]    strb_d;
    logic [5:0]    wb_rd_d;
    logic [63:0]   wdata_d, lane_d, load_val_d;
    // Decode the incoming EX access (alignment, lanes) and extract/extend the returned load lane
    always_comb begin
        off_d        = exmm_aluresult[2:0];
        amask_d      = mem_size == 2'd0 ? 3'b000 : mem_size == 2'd1 ? 3'b001 : mem_size == 2'd2 ? 3'b011 : 3'b111;
        misaligned_d = |(off_d & amask_d);
        strb_d       = (mem_size == 2'd0 ? 8'h01 : mem_size == 2'd1 ? 8'h03 : mem_size == 2'd2 ? 8'h0F : 8'hFF) << off_d;
        wdata_d      = store_data << {off_d, 3'b000};
        wb_rd_d      = dest_reg == 6'd0 ? NO_REG : dest_reg;
        lane_d       = dresp_data >> {addr_q[2:0], 3'b000};
        load_val_d   = size_q == 2'd0 ? {{56{~uns_q & lane_d[7]}}, lane_d[7:0]} :
                       size_q == 2'd1 ? {{48{~uns_q & lane_d[15]}}, lane_d[15:0]} :
                       size_q == 2'd2 ? {{32{~uns_q & lane_d[31]}}, lane_d[31:0]} : lane_d;
    end
    // Control FSM with registered writeback/error outputs; payload latched only when accepted in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            strb_q        <= '0;
            size_q        <= '0;
            write_q       <= 1'b0;
            uns_q         <= 1'b0;
            rd_q          <= NO_REG;
            cnt_q         <= '0;
            memwb_ready_q <= 1'b0;
            memwb_rd_q    <= NO_REG;
            memwb_rdval_q <= '0;
            mem_err_q     <= 1'b0;
        end else begin
            memwb_ready_q <= 1'b0;
            mem_err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (EXMEM_ready) begin
                        if (!mem_active) begin
                            memwb_ready_q <= 1'b1;
                            memwb_rd_q    <= wb_rd_d;
                            memwb_rdval_q <= exmm_aluresult;
                        end else if (misaligned_d) begin
                            memwb_ready_q <= 1'b1;
                            mem_err_q     <= 1'b1;
                            memwb_rd_q    <= NO_REG;
                        end else begin
                            addr_q  <= exmm_aluresult;
                            wdata_q <= wdata_d;
                            strb_q  <= load ? 8'h00 : strb_d;
                            size_q  <= mem_size;
                            write_q <= ~load;
                            uns_q   <= mem_unsigned;
                            rd_q    <= wb_rd_d;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dreq_ready) begin
                        if (write_q) begin
                            memwb_ready_q <= 1'b1;
                            memwb_rd_q    <= NO_REG;
                            state_q       <= IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dresp_valid) begin
                        memwb_ready_q <= 1'b1;
                        memwb_rd_q    <= rd_q;
                        memwb_rdval_q <= load_val_d;
                        state_q       <= IDLE;
                    end else if (cnt_q == CW'(BUS_TIMEOUT - 1)) begin
                        memwb_ready_q <= 1'b1;
                        mem_err_q     <= 1'b1;
                        memwb_rd_q    <= NO_REG;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mem_stall   = state_q != IDLE;
    assign dreq_valid  = state_q == REQ;
    assign dreq_addr   = addr_q;
    assign dreq_write  = write_q;
    assign dreq_wdata  = wdata_q;
    assign dreq_strb   = strb_q;
    assign MEMWB_ready = memwb_ready_q;
    assign memwb_rd    = memwb_rd_q;
    assign memwb_rdval = memwb_rdval_q;
    assign MEMEX_rd    = memwb_rd_q;
    assign MEMEX_rdval = memwb_rdval_q;
    assign mem_err     = mem_err_q;
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: randomized self-checking bench for memory_access_stage against a byte-level model
module tb_memory_access_stage;
    localparam logic [5:0] NO_REG = 6'h3F;
    localparam int         TO     = 255;
    logic        clk = 1'b0;
    logic        reset;
    logic        EXMEM_ready, mem_active, load, mem_unsigned;
    logic [63:0] exmm_aluresult, store_data, dresp_data;
    logic [5:0]  dest_reg;
    logic [1:0]  mem_size;
    logic        mem_stall, dreq_valid, dreq_ready, dreq_write, dresp_valid;
    logic [63:0] dreq_addr, dreq_wdata, MEMEX_rdval, memwb_rdval;
    logic [7:0]  dreq_strb;
    logic [5:0]  MEMEX_rd, memwb_rd;
    logic        MEMWB_ready, mem_err;
    int          nvec = 0;
    int          nerr = 0;
    logic [5:0]  exp_rd;
    logic [63:0] exp_val;
    bit          val_known;

    memory_access_stage dut (
        .clk(clk), .reset(reset), .EXMEM_ready(EXMEM_ready), .exmm_aluresult(exmm_aluresult),
        .dest_reg(dest_reg), .mem_active(mem_active), .load(load), .store_data(store_data),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_stall(mem_stall),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
        .dreq_write(dreq_write), .dreq_wdata(dreq_wdata), .dreq_strb(dreq_strb),
        .dresp_valid(dresp_valid), .dresp_data(dresp_data), .MEMEX_rd(MEMEX_rd),
        .MEMEX_rdval(MEMEX_rdval), .MEMWB_ready(MEMWB_ready), .memwb_rd(memwb_rd),
        .memwb_rdval(memwb_rdval), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ld_model(input logic [63:0] resp, input int off, input int n, input logic un);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = resp[8*(off+i) +: 8];
        if (!un && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] strb_model(input int off, input int n);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] wdata_model(input logic [63:0] sd, input int off);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) if (i >= off) w[8*i +: 8] = sd[8*(i-off) +: 8];
        return w;
    endfunction

    task automatic issue(input logic ma, input logic ld, input logic [63:0] a, input logic [63:0] sd,
                         input logic [1:0] sz, input logic un, input logic [5:0] rd);
        EXMEM_ready = 1'b1; mem_active = ma; load = ld; exmm_aluresult = a; store_data = sd;
        mem_size = sz; mem_unsigned = un; dest_reg = rd;
        tick;
        EXMEM_ready = 1'b0; exmm_aluresult = {$urandom, $urandom}; store_data = {$urandom, $urandom};
        mem_size = 2'($urandom); mem_unsigned = 1'($urandom); load = 1'($urandom); dest_reg = 6'($urandom);
    endtask

    task automatic check_done(input string tag, input logic [5:0] rd, input logic [63:0] val, input bit vk, input bit err);
        chk({tag, " rdy"}, MEMWB_ready, 1);
        chk({tag, " err"}, mem_err, err);
        chk({tag, " rd"}, memwb_rd, rd);
        chk({tag, " fwd_rd"}, MEMEX_rd, rd);
        if (vk) begin
            chk({tag, " val"}, memwb_rdval, val);
            chk({tag, " fwd_val"}, MEMEX_rdval, val);
            exp_val = val;
        end
        chk({tag, " stall"}, mem_stall, 0);
        chk({tag, " dvalid"}, dreq_valid, 0);
        exp_rd = rd;
        val_known = vk;
        tick;
        chk({tag, " rdy_drop"}, MEMWB_ready, 0);
        chk({tag, " err_drop"}, mem_err, 0);
        chk({tag, " hold_rd"}, MEMEX_rd, exp_rd);
        if (val_known) chk({tag, " hold_val"}, MEMEX_rdval, exp_val);
    endtask

    task automatic run_op(input logic ma, input logic ld, input logic [63:0] a, input logic [63:0] sd,
                          input logic [1:0] sz, input logic un, input logic [5:0] rd,
                          input int hold, input int lat, input logic [63:0] resp);
        int n, off;
        n = 1 << sz;
        off = int'(a[2:0]);
        issue(ma, ld, a, sd, sz, un, rd);
        if (!ma) begin
            check_done("alu", rd == 6'd0 ? NO_REG : rd, a, 1, 0);
        end else if (off % n != 0) begin
            check_done("misal", NO_REG, 64'd0, 0, 1);
        end else begin
            for (int h = 0; h <= hold; h++) begin
                chk("req valid", dreq_valid, 1);
                chk("req stall", mem_stall, 1);
                chk("req addr", dreq_addr, a);
                chk("req write", dreq_write, !ld);
                chk("req wbrdy", MEMWB_ready, 0);
                if (!ld) begin
                    chk("req strb", dreq_strb, strb_model(off, n));
                    chk("req wdata", dreq_wdata, wdata_model(sd, off));
                end
                dreq_ready = (h == hold);
                dresp_valid = 1'($urandom);
                dresp_data = {$urandom, $urandom};
                EXMEM_ready = 1'($urandom);
                mem_active = 1'b0;
                tick;
                dreq_ready = 1'b0; dresp_valid = 1'b0; EXMEM_ready = 1'b0;
            end
            if (!ld) begin
                check_done("st", NO_REG, 64'd0, 0, 0);
            end else begin
                chk("wait valid", dreq_valid, 0);
                chk("wait stall", mem_stall, 1);
                if (lat >= 0) begin
                    repeat (lat) begin
                        EXMEM_ready = 1'($urandom);
                        dreq_ready = 1'($urandom);
                        tick;
                        EXMEM_ready = 1'b0; dreq_ready = 1'b0;
                    end
                    chk("wait wbrdy", MEMWB_ready, 0);
                    dresp_valid = 1'b1;
                    dresp_data = resp;
                    tick;
                    dresp_valid = 1'b0;
                    check_done("ld", rd == 6'd0 ? NO_REG : rd, ld_model(resp, off, n, un), 1, 0);
                end else begin
                    repeat (TO - 1) tick;
                    chk("tmo stall", mem_stall, 1);
                    chk("tmo early_err", mem_err, 0);
                    chk("tmo early_rdy", MEMWB_ready, 0);
                    tick;
                    check_done("tmo", NO_REG, 64'd0, 0, 1);
                    dresp_valid = 1'b1;
                    dresp_data = resp;
                    tick;
                    dresp_valid = 1'b0;
                    chk("late resp rdy", MEMWB_ready, 0);
                    chk("late resp stall", mem_stall, 0);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; EXMEM_ready = 1'b0; mem_active = 1'b0; load = 1'b0; mem_unsigned = 1'b0;
        exmm_aluresult = '0; store_data = '0; dresp_data = '0; dest_reg = '0; mem_size = '0;
        dreq_ready = 1'b0; dresp_valid = 1'b0;
        tick;
        tick;
        chk("rst wbrdy", MEMWB_ready, 0);
        chk("rst memwb_rd", memwb_rd, NO_REG);
        chk("rst fwd_rd", MEMEX_rd, NO_REG);
        chk("rst rdval", memwb_rdval, 0);
        chk("rst stall", mem_stall, 0);
        chk("rst dvalid", dreq_valid, 0);
        chk("rst err", mem_err, 0);
        chk("rst strb", dreq_strb, 0);
        chk("rst write", dreq_write, 0);
        exp_rd = NO_REG; exp_val = '0; val_known = 1;
        reset = 1'b0;
        tick;
        run_op(0, 0, 64'h1234, 0, 0, 0, 6'd5, 0, 0, 0);
        run_op(0, 0, 64'h55, 0, 0, 0, 6'd0, 0, 0, 0);
        run_op(1, 1, 64'h1003, 0, 2'd0, 0, 6'd7, 0, 0, 64'h0000_0000_8000_0000);
        chk("lb value", memwb_rdval, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1, 1, 64'h1003, 0, 2'd0, 1, 6'd8, 1, 2, 64'h0000_0000_8000_0000);
        chk("lbu value", memwb_rdval, 64'h80);
        run_op(1, 0, 64'h1004, 64'hDEADBEEF, 2'd2, 0, 6'd9, 3, 0, 0);
        run_op(1, 1, 64'h1004, 0, 2'd3, 0, 6'd10, 0, 0, 0);
        run_op(1, 1, 64'h2008, 0, 2'd3, 0, 6'd11, 0, -1, 64'h1111);
        // reset while a store request is pending on the bus
        issue(1, 0, 64'h3000, 64'hABCD, 2'd3, 0, 6'd1);
        #3;
        chk("rreq valid_before", dreq_valid, 1);
        reset = 1'b1;
        #1;
        chk("rreq valid_async", dreq_valid, 0);
        chk("rreq stall", mem_stall, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick;
        chk("rreq wbrdy", MEMWB_ready, 0);
        // reset while waiting for load data
        issue(1, 1, 64'h4000, 0, 2'd3, 0, 6'd2);
        dreq_ready = 1'b1;
        tick;
        dreq_ready = 1'b0;
        tick;
        chk("rwait stall_before", mem_stall, 1);
        #3 reset = 1'b1;
        #1;
        chk("rwait dvalid", dreq_valid, 0);
        chk("rwait stall", mem_stall, 0);
        chk("rwait fwd_rd", MEMEX_rd, NO_REG);
        chk("rwait wbrdy", MEMWB_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        dresp_valid = 1'b1;
        dresp_data = 64'h77;
        tick;
        dresp_valid = 1'b0;
        chk("rwait late_resp", MEMWB_ready, 0);
        exp_rd = NO_REG; exp_val = '0; val_known = 1;
        for (int k = 0; k < 200; k++) begin
            run_op($urandom_range(0, 3) != 0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   2'($urandom), 1'($urandom), 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 4),
                   {$urandom, $urandom});
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
